// File: rtl/audio_i2s_tx.sv
// I2S stereo transmitter with a small sample FIFO, 12.288 MHz master clock, 256-cycle frames.
// Build option: define AUDIO_I2S_MUTE_ON_UNDERFLOW_EN to output silence on underflow instead of repeating the last sample.
module audio_i2s_tx #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_12_288_mhz,
    input  logic        reset_n,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        i2s_sclk,
    output logic        i2s_lrck,
    output logic        i2s_dac,
    output logic [7:0]  underflow_count
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned WORD_W   = 2 * SAMPLE_W;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [7:0]          phase;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;

    logic       push_c;
    logic       pop_c;
    logic       frame_end_c;
    logic       empty_c;
    logic       in_word_c;
    logic       dac_c;
    logic [5:0] slot_c;
    logic [4:0] slot_lo_c;
    logic [3:0] bit_idx_c;

    // Occupancy is registered, so a push in the frame-end cycle is invisible to that cycle's pop.
    assign sample_ready = (count != CNT_W'(FIFO_DEPTH));
    assign empty_c      = (count == '0);
    assign frame_end_c  = (phase == 8'hFF);
    assign push_c       = sample_valid && sample_ready;
    assign pop_c        = frame_end_c && !empty_c;

    // Slot decode: slot 1..16 of each half carries bits 15..0, everything else is zero.
    always_comb begin
        slot_c    = phase[7:2];
        slot_lo_c = slot_c[4:0];
        bit_idx_c = 4'(5'd16 - slot_lo_c);
        in_word_c = (slot_lo_c >= 5'd1) && (slot_lo_c <= 5'd16);
        dac_c     = 1'b0;
        if (in_word_c) begin
            dac_c = slot_c[5] ? hold_r[bit_idx_c] : hold_l[bit_idx_c];
        end
    end

    // Phase counter and registered serial outputs (one cycle behind their decoded phase).
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            i2s_sclk <= 1'b0;
            i2s_lrck <= 1'b0;
            i2s_dac  <= 1'b0;
        end else begin
            phase    <= phase + 8'd1;
            i2s_sclk <= phase[1];
            i2s_lrck <= phase[7];
            i2s_dac  <= dac_c;
        end
    end

    always_ff @(posedge clk_12_288_mhz) begin
        if (push_c) begin
            mem[wr_ptr] <= {sample_left, sample_right};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame-end load of the holding registers, or underflow handling.
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            hold_l          <= '0;
            hold_r          <= '0;
            underflow_count <= '0;
        end else if (frame_end_c) begin
            if (!empty_c) begin
                {hold_l, hold_r} <= mem[rd_ptr];
            end else begin
                if (underflow_count != 8'hFF) begin
                    underflow_count <= underflow_count + 8'd1;
                end
`ifdef AUDIO_I2S_MUTE_ON_UNDERFLOW_EN
                hold_l <= '0;
                hold_r <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, stereo sample FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk_12_288_mhz  in  1  audio master clock, 12.288 MHz, the only clock.
REQ-003 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port sample_left  in  16  signed left sample from the core's sound path, already in this clock domain.
REQ-005 SHALL have port sample_right  in  16  signed right sample; the core drives it equal to sample_left for mono.
REQ-006 SHALL have port sample_valid  in  1  producer offers {sample_left, sample_right}.
REQ-007 SHALL have port sample_ready  out  1  FIFO can accept a push this cycle.
REQ-008 SHALL have port i2s_sclk  out  1  bit clock, clk/4 = 3.072 MHz.
REQ-009 SHALL have port i2s_lrck  out  1  word select; 0 = left, 1 = right; 48 kHz.
REQ-010 SHALL have port i2s_dac  out  1  serial data, MSB first, I2S (one-bit-delayed) format.
REQ-011 SHALL have port underflow_count  out  8  saturating count of frames started with an empty FIFO.

Function
REQ-012 SHALL keep an 8-bit phase counter that increments every cycle and wraps 255->0; one frame = 256 cycles.
REQ-013 SHALL define slot = phase[7:2] (0..63); slots 0..31 are the left half and slots 32..63 are the right half.
REQ-014 SHALL register i2s_sclk, i2s_lrck and i2s_dac from the phase counter, so each lags its decoded phase by exactly 1 cycle.
REQ-015 SHALL decode i2s_sclk as phase[1]: low for phase[1:0] = 0,1 and high for phase[1:0] = 2,3, so data is stable at the sclk rising edge.
REQ-016 SHALL decode i2s_lrck as phase[7].
REQ-017 SHALL drive i2s_dac in slots 1..16 with bits 15..0 of the left holding register, and in slots 33..48 with bits 15..0 of the right holding register.
REQ-018 SHALL drive i2s_dac to 0 in all other slots (0, 17..32, 49..63).
REQ-019 SHALL pop the FIFO head into the left/right holding registers at phase 255 when the FIFO is non-empty; the new word is first output at slot 1 of the next frame.
REQ-020 SHALL treat phase 255 with an empty FIFO as an underflow: no pop, holding registers per REQ-030, and underflow_count increments, saturating at 255.
REQ-021 SHALL drive sample_ready = !full, decoded from the registered occupancy count.
REQ-022 SHALL push on sample_valid && sample_ready; when ready is low, sample_valid is ignored and the data is dropped silently (the producer free-runs).
REQ-023 SHALL, on a push and pop in the same cycle, leave occupancy unchanged and keep FIFO order intact.
REQ-024 SHALL, when a push and phase 255 coincide with an empty FIFO, not let the pop see the pushed entry: that frame underflows and the entry is popped at the next phase 255.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and distinguish full from empty with a separate occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-026 SHALL give end-to-end latency of 2..(FIFO_DEPTH+1) frames from push to first dac bit, depending on occupancy.

Reset
REQ-027 SHALL, while reset_n is low, force phase = 0, i2s_sclk = 0, i2s_lrck = 0, i2s_dac = 0, FIFO empty, holding registers = 0, underflow_count = 0, and sample_ready = 1.
REQ-028 SHALL, when reset_n is asserted mid-frame, abort the current word immediately; after release, the first frame starts at phase 0 with zero holding registers.
REQ-029 SHALL let the design rely on reset_n being released synchronously to clk_12_288_mhz by the enclosing core.

Configuration
REQ-030 SHALL, on underflow with AUDIO_I2S_MUTE_ON_UNDERFLOW_EN defined, load 0 into both holding registers (silence); with it undefined, retain the previous holding values (repeat last sample).

Verification
REQ-031 SHALL cover: push L=16'h8001, R=16'h7FFE into an empty FIFO at phase 10 -> next frame shows lrck=0, dac bits 1000_0000_0000_0001 in slots 1..16, then lrck=1, bits 0111_1111_1111_1110 in slots 33..48.
REQ-032 SHALL cover: assert sample_valid continuously with FIFO_DEPTH=4 -> sample_ready falls after 4 pushes, rises 1 cycle after each phase-255 pop, and every accepted word is emitted in order.
REQ-033 SHALL cover: no pushes for 3 frames after one word 16'h1234 -> underflow_count = 3; without the macro, 16'h1234 repeats; with the macro, 16'h0000 is output.
REQ-034 SHALL cover: push coincident with phase 255 on an empty FIFO -> underflow_count +1, and the word is output one frame later.
REQ-035 SHALL cover: reset_n pulsed low at phase 100 mid-left-word -> all outputs 0 immediately; after release, i2s_sclk rises at cycle 3 and i2s_lrck rises at cycle 129.
REQ-036 SHALL cover: 300 underflow frames -> underflow_count holds at 255.
